// File: rtl/rep_hist.sv
// Position-history manager in front of the repetition detector: owns the history
// stack and RAM write port, and sequences the detector query handshake.
module rep_hist #(
  parameter int REPDET_WIDTH = 8,
  parameter int BOARD_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_push,
  input  logic                    cmd_pop,
  input  logic                    cmd_clear,
  input  logic                    cmd_query,
  input  logic [BOARD_WIDTH-1:0]  push_board,
  input  logic [3:0]              push_castle_mask,
  input  logic [BOARD_WIDTH-1:0]  query_board,
  input  logic [3:0]              query_castle_mask,
  output logic                    cmd_ready,
  output logic                    result_rep,
  output logic                    result_valid,
  output logic [REPDET_WIDTH-1:0] depth,
  output logic                    full,
  output logic                    empty,
  output logic                    error,
  output logic [BOARD_WIDTH-1:0]  ram_board,
  output logic [3:0]              ram_castle_mask,
  output logic [REPDET_WIDTH-1:0] ram_wr_addr,
  output logic                    ram_wr_en,
  output logic [REPDET_WIDTH-1:0] ram_depth,
  output logic [BOARD_WIDTH-1:0]  board,
  output logic [3:0]              castle_mask,
  output logic                    board_valid,
  output logic                    clear_sample,
  input  logic                    thrice_rep,
  input  logic                    thrice_rep_valid
);

  typedef enum logic [1:0] {IDLE, Q_ISSUE, Q_WAIT, Q_DRAIN} state_t;

  state_t state_r, next_state_s;
  logic   multi_s, do_push_s, do_pop_s, do_clear_s, do_query_s, set_err_s;
  logic   capture_s;

  assign cmd_ready = (state_r == IDLE);
  assign full      = (depth == {REPDET_WIDTH{1'b1}});
  assign empty     = (depth == {REPDET_WIDTH{1'b0}});
  assign ram_depth = depth;
  assign multi_s   = (cmd_push & cmd_pop) | (cmd_push & cmd_query) | (cmd_pop & cmd_query);
  assign capture_s = (state_r == Q_WAIT) & thrice_rep_valid;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // command decode and next-state logic; clear outranks every other command
  always_comb begin
    next_state_s = state_r;
    do_push_s    = 1'b0;
    do_pop_s     = 1'b0;
    do_clear_s   = 1'b0;
    do_query_s   = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_clear) begin
          do_clear_s = 1'b1;
        end else if (multi_s) begin
          set_err_s = 1'b1;
        end else if (cmd_push) begin
          if (full) set_err_s = 1'b1;
          else      do_push_s = 1'b1;
        end else if (cmd_pop) begin
          if (empty) set_err_s = 1'b1;
          else       do_pop_s  = 1'b1;
        end else if (cmd_query) begin
          do_query_s   = 1'b1;
          next_state_s = Q_ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      Q_ISSUE: next_state_s = Q_WAIT;
      Q_WAIT: begin
        if (thrice_rep_valid) next_state_s = Q_DRAIN;
        else                  next_state_s = Q_WAIT;
      end
      Q_DRAIN: begin
        if (!thrice_rep_valid) next_state_s = IDLE;
        else                   next_state_s = Q_DRAIN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // history depth, sticky error and RAM write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth           <= {REPDET_WIDTH{1'b0}};
      error           <= 1'b0;
      ram_wr_en       <= 1'b0;
      ram_wr_addr     <= {REPDET_WIDTH{1'b0}};
      ram_board       <= {BOARD_WIDTH{1'b0}};
      ram_castle_mask <= 4'b0000;
    end else begin
      ram_wr_en <= do_push_s;
      if (do_clear_s) begin
        depth <= {REPDET_WIDTH{1'b0}};
        error <= 1'b0;
      end else begin
        if (set_err_s) error <= 1'b1;
        if (do_push_s) depth <= depth + REPDET_WIDTH'(1);
        if (do_pop_s)  depth <= depth - REPDET_WIDTH'(1);
      end
      if (do_push_s) begin
        ram_wr_addr     <= depth;
        ram_board       <= push_board;
        ram_castle_mask <= push_castle_mask;
      end
    end
  end

  // detector query port and result pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board        <= {BOARD_WIDTH{1'b0}};
      castle_mask  <= 4'b0000;
      board_valid  <= 1'b0;
      clear_sample <= 1'b0;
      result_rep   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (do_query_s) begin
        board       <= query_board;
        castle_mask <= query_castle_mask;
      end
      board_valid  <= (state_r == Q_ISSUE);
      result_valid <= capture_s;
      if (capture_s) begin
        result_rep   <= thrice_rep;
        clear_sample <= 1'b1;
      end else if ((state_r == Q_DRAIN) && !thrice_rep_valid) begin
        clear_sample <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rep_hist.sv
// Scoreboard bench for rep_hist with a behavioural repetition detector
// (fixed latency, counts matching history entries, answers >=3).
module tb_rep_hist;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_push, cmd_pop, cmd_clear, cmd_query;
  logic [63:0] push_board, query_board;
  logic [3:0]  push_castle_mask, query_castle_mask;
  logic        cmd_ready, result_rep, result_valid, full, empty, error;
  logic [7:0]  depth, ram_wr_addr, ram_depth;
  logic [63:0] ram_board, board;
  logic [3:0]  ram_castle_mask, castle_mask;
  logic        ram_wr_en, board_valid, clear_sample, thrice_rep, thrice_rep_valid;

  logic        s_push, s_pop;
  logic        s_ready, s_rep, s_rvalid, s_full, s_empty, s_error, s_wr_en, s_bvalid, s_clr;
  logic [1:0]  s_depth, s_wr_addr, s_ram_depth;
  logic [63:0] s_ram_board, s_board;
  logic [3:0]  s_ram_cm, s_cm;
  int          s_wr_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;
  logic        res_q[$];
  logic [75:0] ram_q[$];

  logic [63:0] tb_ram_b [256];
  logic [3:0]  tb_ram_c [256];
  logic [2:0]  det_cnt;

  localparam logic [63:0] POS_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] POS_B = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] POS_C = 64'h0F0F_0F0F_0F0F_0F0F;

  always #5 clk = ~clk;

  rep_hist #(.REPDET_WIDTH(8), .BOARD_WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_push(cmd_push), .cmd_pop(cmd_pop), .cmd_clear(cmd_clear), .cmd_query(cmd_query),
    .push_board(push_board), .push_castle_mask(push_castle_mask),
    .query_board(query_board), .query_castle_mask(query_castle_mask),
    .cmd_ready(cmd_ready), .result_rep(result_rep), .result_valid(result_valid),
    .depth(depth), .full(full), .empty(empty), .error(error),
    .ram_board(ram_board), .ram_castle_mask(ram_castle_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_en(ram_wr_en), .ram_depth(ram_depth),
    .board(board), .castle_mask(castle_mask), .board_valid(board_valid),
    .clear_sample(clear_sample), .thrice_rep(thrice_rep), .thrice_rep_valid(thrice_rep_valid)
  );

  rep_hist #(.REPDET_WIDTH(2), .BOARD_WIDTH(64)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .cmd_push(s_push), .cmd_pop(s_pop), .cmd_clear(1'b0), .cmd_query(1'b0),
    .push_board(POS_C), .push_castle_mask(4'h5),
    .query_board(64'h0), .query_castle_mask(4'h0),
    .cmd_ready(s_ready), .result_rep(s_rep), .result_valid(s_rvalid),
    .depth(s_depth), .full(s_full), .empty(s_empty), .error(s_error),
    .ram_board(s_ram_board), .ram_castle_mask(s_ram_cm), .ram_wr_addr(s_wr_addr),
    .ram_wr_en(s_wr_en), .ram_depth(s_ram_depth),
    .board(s_board), .castle_mask(s_cm), .board_valid(s_bvalid),
    .clear_sample(s_clr), .thrice_rep(1'b0), .thrice_rep_valid(1'b0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_match(input logic [63:0] b, input logic [3:0] m, input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (i < int'(d) && tb_ram_b[i] == b && tb_ram_c[i] == m) n++;
    return n;
  endfunction

  // behavioural detector history RAM
  always @(posedge clk)
    if (ram_wr_en) begin
      tb_ram_b[ram_wr_addr] <= ram_board;
      tb_ram_c[ram_wr_addr] <= ram_castle_mask;
    end

  // behavioural detector: answer 3 cycles after board_valid, hold until clear_sample
  always @(posedge clk) begin
    if (!reset_n) begin
      det_cnt <= 3'd0; thrice_rep <= 1'b0; thrice_rep_valid <= 1'b0;
    end else if (board_valid) begin
      det_cnt    <= 3'd3;
      thrice_rep <= (count_match(board, castle_mask, ram_depth) >= 3);
    end else if (det_cnt == 3'd1) begin
      det_cnt <= 3'd0; thrice_rep_valid <= 1'b1;
    end else if (det_cnt != 3'd0) begin
      det_cnt <= det_cnt - 3'd1;
    end else if (thrice_rep_valid && clear_sample) begin
      thrice_rep_valid <= 1'b0;
    end
  end

  // monitor: pops scoreboards on output events
  always @(negedge clk) begin
    if (reset_n) begin
      if (result_valid) begin
        if (res_q.size() == 0) chk("spurious_result_valid", result_valid, 1'b0);
        else chk("result_rep", result_rep, res_q.pop_front());
      end
      if (ram_wr_en) begin
        if (ram_q.size() == 0) chk("spurious_ram_wr_en", ram_wr_en, 1'b0);
        else chk("ram_write", {ram_wr_addr, ram_castle_mask, ram_board}, ram_q.pop_front());
      end
      if (s_wr_en) s_wr_cnt <= s_wr_cnt + 1;
    end
  end

  task automatic issue(input logic p, input logic po, input logic c, input logic q,
                       input logic [63:0] b, input logic [3:0] m);
    cmd_push = p; cmd_pop = po; cmd_clear = c; cmd_query = q;
    push_board = b; push_castle_mask = m; query_board = b; query_castle_mask = m;
    @(posedge clk); #1;
    cmd_push = 1'b0; cmd_pop = 1'b0; cmd_clear = 1'b0; cmd_query = 1'b0;
  endtask

  task automatic push(input logic [63:0] b, input logic [3:0] m, input logic [7:0] addr);
    ram_q.push_back({addr, m, b});
    issue(1'b1, 1'b0, 1'b0, 1'b0, b, m);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_within_budget", cmd_ready, 1'b1);
  endtask

  task automatic query(input logic [63:0] b, input logic [3:0] m, input logic exp);
    res_q.push_back(exp);
    issue(1'b0, 1'b0, 1'b0, 1'b1, b, m);
    chk("q_ready_low", cmd_ready, 1'b0);
    chk("q_bvalid_early", board_valid, 1'b0);
    @(posedge clk); #1;
    chk("q_bvalid", board_valid, 1'b1);
    chk("q_board", {castle_mask, board}, {m, b});
    @(posedge clk); #1;
    chk("q_bvalid_one_cycle", board_valid, 1'b0);
    wait_ready();
    chk("ready_after_drop", thrice_rep_valid, 1'b0);
    chk("clear_sample_idle", clear_sample, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_push = 1'b0; cmd_pop = 1'b0; cmd_clear = 1'b0; cmd_query = 1'b0;
    push_board = 64'h0; push_castle_mask = 4'h0; query_board = 64'h0; query_castle_mask = 4'h0;
    s_push = 1'b0; s_pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {depth, empty, full, error, cmd_ready}, {8'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("rst_strobes", {result_valid, result_rep, ram_wr_en, board_valid, clear_sample},
        5'b00000);
    chk("rst_data", {ram_wr_addr, ram_castle_mask, ram_board, castle_mask, board}, 128'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    push(POS_A, 4'hF, 8'd0);
    push(POS_B, 4'hF, 8'd1);
    push(POS_A, 4'hF, 8'd2);
    push(POS_B, 4'hF, 8'd3);
    push(POS_A, 4'hF, 8'd4);
    @(posedge clk); #1;
    chk("depth_after_5_push", {depth, ram_depth, error, empty}, {8'd5, 8'd5, 1'b0, 1'b0});

    query(POS_A, 4'hF, 1'b1);
    query(POS_B, 4'hF, 1'b0);
    query(POS_A, 4'h3, 1'b0);
    chk("depth_after_queries", depth, 8'd5);

    // commands in Q_WAIT are ignored; then reset mid-query
    issue(1'b0, 1'b0, 1'b0, 1'b1, POS_C, 4'h1);
    @(posedge clk); #1;
    cmd_push = 1'b1; push_board = POS_C;
    @(posedge clk); #1;
    cmd_push = 1'b0; cmd_query = 1'b1;
    @(posedge clk); #1;
    cmd_query = 1'b0;
    chk("qwait_ignored", {depth, cmd_ready, ram_wr_en}, {8'd5, 1'b0, 1'b0});
    reset_n = 1'b0;
    #1;
    chk("midq_rst_flags", {depth, empty, error, cmd_ready}, {8'd0, 1'b1, 1'b0, 1'b1});
    chk("midq_rst_strobes", {board_valid, clear_sample, result_valid, ram_wr_en, board},
        {4'b0000, 64'h0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    query(POS_A, 4'hF, 1'b0);

    issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0);
    chk("pop_empty", {depth, error}, {8'd0, 1'b1});
    issue(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 4'h0);
    chk("clear_err", {depth, error}, {8'd0, 1'b0});

    push(POS_B, 4'h2, 8'd0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, POS_C, 4'h7);
    @(posedge clk); #1;
    chk("push_pop_multi", {depth, error}, {8'd1, 1'b1});
    issue(1'b1, 1'b0, 1'b1, 1'b0, POS_C, 4'h7);
    @(posedge clk); #1;
    chk("clear_push", {depth, error, empty}, {8'd0, 1'b0, 1'b1});

    // REPDET_WIDTH=2 instance: overflow at depth 3
    for (int i = 0; i < 4; i++) begin
      s_push = 1'b1;
      @(posedge clk); #1;
      s_push = 1'b0;
      if (i == 2) chk("small_full", {s_depth, s_full, s_error}, {2'd3, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    chk("small_overflow", {s_wr_cnt[7:0], s_depth, s_full, s_error}, {8'd3, 2'd3, 1'b1, 1'b1});
    s_pop = 1'b1;
    @(posedge clk); #1;
    s_pop = 1'b0;
    chk("small_pop", {s_depth, s_full}, {2'd2, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("result_q_drained", res_q.size(), 0);
    chk("ram_q_drained", ram_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
